// File: rtl/pack_collect_if.sv
// pack_collect_if -- trace-in / packet-out signal bundle for pack_collect.
//
// Signals:
//   width        trace port width select (00=1, 01=2, 1x=4 bits per element)
//   sync         collector is frame-aligned to the trace stream
//   TraceAvail   upstream has a trace element ready
//   TraceNext    one-clk strobe consuming the current TraceIn element
//   TraceIn      trace element, LSB is the earliest bit
//   PacketAvail  a complete 16-byte frame is held and not yet taken
//   PacketNext   take the held frame into the read buffer
//   PacketNextWd advance to the next 16-bit word of the read buffer
//   PacketOut    current read-buffer word
//   PacketFinal  last byte (byte 15) of the read-buffer frame
//
// master: the side that supplies trace data and reads packets.
// slave:  the collector itself.
interface pack_collect_if;
  logic [1:0]  width;
  logic        sync;
  logic        TraceAvail;
  logic        TraceNext;
  logic [3:0]  TraceIn;
  logic        PacketAvail;
  logic        PacketNext;
  logic        PacketNextWd;
  logic [15:0] PacketOut;
  logic [7:0]  PacketFinal;

  modport master (
    output width, TraceAvail, TraceIn, PacketNext, PacketNextWd,
    input  sync, TraceNext, PacketAvail, PacketOut, PacketFinal
  );

  modport slave (
    input  width, TraceAvail, TraceIn, PacketNext, PacketNextWd,
    output sync, TraceNext, PacketAvail, PacketOut, PacketFinal
  );
endinterface

// File: rtl/pack_collect.sv
// pack_collect -- bit-serial trace frame collector.
//
// Consumes 1/2/4-bit trace elements, hunts for the frame sync word
// (31 ones followed by a zero, i.e. bytes FF FF FF 7F), then packs the
// following bits into 16-byte frames. A completed frame sits in a hold
// buffer until PacketNext moves it into a read buffer, which is then
// walked one 16-bit word at a time with PacketNextWd.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  pack_collect_if.slave (trace input, packet output, see interface)
module pack_collect (
  input  logic           clk,
  input  logic           rst,
  pack_collect_if.slave  bus
);

  localparam logic [31:0] SYNC_WORD = 32'h7FFF_FFFF;

  // ---------------------------------------------------------------
  // Trace handshake: one strobe per element. The element is captured
  // on the clock edge that ends the strobe cycle, and the FSM always
  // spends at least one cycle idle afterwards so the upstream has a
  // chance to present the next element (or drop TraceAvail).
  // ---------------------------------------------------------------
  typedef enum logic {
    ST_IDLE,
    ST_STROBE
  } trace_state_t;

  trace_state_t state_reg, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.TraceAvail) state_next = ST_STROBE;
      ST_STROBE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  logic capture;
  assign capture       = (state_reg == ST_STROBE);
  assign bus.TraceNext = capture;

  // Which TraceIn lanes carry valid bits for the selected width.
  logic [3:0] lane_en;
  always_comb begin
    case (bus.width)
      2'b00:   lane_en = 4'b0001;
      2'b01:   lane_en = 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // ---------------------------------------------------------------
  // Bit-serial window, byte assembly and frame store.
  // Bits are walked one at a time inside an element so that a sync
  // match (or a byte boundary) can land on any bit of the element.
  // ---------------------------------------------------------------
  logic [31:0] window_reg, window_next;
  logic        sync_reg, sync_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  byte_reg, byte_next;
  logic [3:0]  idx_reg, idx_next;
  logic [7:0]  frame_reg [16];
  logic [7:0]  frame_next [16];
  logic        frame_done;

  always_comb begin
    window_next  = window_reg;
    sync_next    = sync_reg;
    bit_cnt_next = bit_cnt_reg;
    byte_next    = byte_reg;
    idx_next     = idx_reg;
    frame_done   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      frame_next[i] = frame_reg[i];
    end

    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          // Newest bit enters at the top, so the oldest bit ends at bit 0.
          window_next = {bus.TraceIn[i], window_next[31:1]};
          if (window_next == SYNC_WORD) begin
            // Realign: any partially collected frame is abandoned.
            sync_next    = 1'b1;
            bit_cnt_next = 3'd0;
            idx_next     = 4'd0;
          end else if (sync_next) begin
            byte_next = {bus.TraceIn[i], byte_next[7:1]};
            if (bit_cnt_next == 3'd7) begin
              frame_next[idx_next] = byte_next;
              if (idx_next == 4'd15) begin
                frame_done = 1'b1;
              end
              idx_next = idx_next + 4'd1;  // wraps 15 -> 0
            end
            bit_cnt_next = bit_cnt_next + 3'd1;  // wraps 7 -> 0
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_reg  <= '0;
      sync_reg    <= 1'b0;
      bit_cnt_reg <= '0;
      byte_reg    <= '0;
      idx_reg     <= '0;
    end else begin
      window_reg  <= window_next;
      sync_reg    <= sync_next;
      bit_cnt_reg <= bit_cnt_next;
      byte_reg    <= byte_next;
      idx_reg     <= idx_next;
    end
  end

  assign bus.sync = sync_reg;

  // ---------------------------------------------------------------
  // Hold and read buffers.
  // take: a held frame is moved to the read buffer. When a frame
  // completes in the same clk, the read buffer still gets the old
  // hold contents and the hold buffer takes the new frame.
  // ---------------------------------------------------------------
  logic [7:0] hold_reg [16];
  logic [7:0] read_reg [16];
  logic       avail_reg;
  logic       take;

  assign take = bus.PacketNext && avail_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        frame_reg[i] <= '0;
        hold_reg[i]  <= '0;
        read_reg[i]  <= '0;
      end
      avail_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        frame_reg[i] <= frame_next[i];
        if (frame_done) begin
          hold_reg[i] <= frame_next[i];
        end
        if (take) begin
          read_reg[i] <= hold_reg[i];
        end
      end
      if (frame_done) begin
        avail_reg <= 1'b1;
      end else if (take) begin
        avail_reg <= 1'b0;
      end
    end
  end

  assign bus.PacketAvail = avail_reg;

  // Word k of the read buffer is {byte 2k+1, byte 2k}.
  logic [15:0] words [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    assign words[gi] = {read_reg[2*gi+1], read_reg[2*gi]};
  end

  // ---------------------------------------------------------------
  // Word pointer: 0 means "before word 0", 1..8 select word 0..7.
  // It saturates on the last word.
  // ---------------------------------------------------------------
  logic [3:0]  ptr_reg;
  logic [3:0]  ptr_adv;
  logic [3:0]  ptr_adv_m1;
  logic [2:0]  word_sel;
  logic [15:0] out_reg;
  logic [7:0]  final_reg;

  assign ptr_adv    = (ptr_reg == 4'd8) ? 4'd8 : (ptr_reg + 4'd1);
  assign ptr_adv_m1 = ptr_adv - 4'd1;
  assign word_sel   = ptr_adv_m1[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      out_reg   <= '0;
      final_reg <= '0;
    end else if (take) begin
      // Taking a frame wins over a word advance in the same clk.
      ptr_reg   <= 4'd0;
      out_reg   <= '0;
      final_reg <= hold_reg[15];
    end else if (bus.PacketNextWd) begin
      ptr_reg <= ptr_adv;
      out_reg <= words[word_sel];
    end
  end

  assign bus.PacketOut   = out_reg;
  assign bus.PacketFinal = final_reg;

endmodule

// File: tb/tb_pack_collect.sv
module tb_pack_collect;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pack_collect_if bus();

  pack_collect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  logic [15:0] exp_q[$];
  bit          bits_q[$];
  logic [7:0]  f1 [16];
  logic [7:0]  f2 [16];
  int          eb;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bits_q.push_back(b[i]);
  endtask

  task automatic push_sync();
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h7F);
  endtask

  // Expected read-out words go to the scoreboard as the frame is queued.
  task automatic push_frame(input logic [7:0] fr [16], input bit score);
    int kk;
    for (int i = 0; i < 16; i++) push_byte(fr[i]);
    if (score) begin
      for (int k = 0; k < 9; k++) begin
        kk = (k > 7) ? 7 : k;
        exp_q.push_back({fr[2*kk+1], fr[2*kk]});
      end
    end
  endtask

  task automatic send_elem(input logic [3:0] v);
    int n = 0;
    bus.TraceIn    = v;
    bus.TraceAvail = 1'b1;
    while (bus.TraceNext !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      $error("FAIL trace_next_timeout observed=0 expected=1");
    end
    @(negedge clk);  // capture edge has passed
    bus.TraceAvail = 1'b0;
  endtask

  task automatic send_stream(input int n, input int end_bit, input bit check_pre);
    logic [3:0] v;
    int e = 0;
    int cnt;
    int last_elem;
    last_elem = (end_bit < 0) ? -1 : end_bit / n;
    while (bits_q.size() > 0) begin
      v = 4'd0;
      for (int i = 0; i < n; i++) if (bits_q.size() > 0) v[i] = bits_q.pop_front();
      if (e == last_elem && check_pre) check("avail_before_last", bus.PacketAvail, 0);
      send_elem(v);
      if (e == last_elem) begin
        cnt = 1;
        while (bus.PacketAvail !== 1'b1 && cnt < 4) begin
          @(negedge clk);
          cnt++;
        end
        check("avail_within_4", bus.PacketAvail, 1);
      end
      e++;
    end
  endtask

  task automatic read_packet(input logic [7:0] exp_final);
    bus.PacketNext = 1'b1;
    @(negedge clk);
    bus.PacketNext = 1'b0;
    check("avail_after_next", bus.PacketAvail, 0);
    check("final", bus.PacketFinal, exp_final);
    check("out_before_wd", bus.PacketOut, 0);
    for (int k = 0; k < 9; k++) begin
      bus.PacketNextWd = 1'b1;
      @(negedge clk);
      bus.PacketNextWd = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
        check($sformatf("word%0d", k), bus.PacketOut, exp_q.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    f1 = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13,
           8'h04, 8'h14, 8'h05, 8'h15, 8'h06, 8'h16, 8'h07, 8'h68};
    for (int i = 0; i < 16; i++) f2[i] = 8'h20 + 8'(i * 17);
    f2[15] = 8'hA5;

    rst = 1'b1;
    bus.width = 2'b00;
    bus.TraceAvail = 1'b0;
    bus.TraceIn = 4'd0;
    bus.PacketNext = 1'b0;
    bus.PacketNextWd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sync", bus.sync, 0);
    check("rst_tracenext", bus.TraceNext, 0);
    check("rst_avail", bus.PacketAvail, 0);
    check("rst_out", bus.PacketOut, 0);
    check("rst_final", bus.PacketFinal, 0);
    rst = 1'b0;
    @(negedge clk);

    // Unsynced junk at width 1
    push_byte(8'hFE); push_byte(8'h23);
    send_stream(1, -1, 0);
    check("nosync_sync", bus.sync, 0);
    check("nosync_avail", bus.PacketAvail, 0);

    // Width 1: sync + frame
    push_sync();
    push_frame(f1, 1);
    eb = bits_q.size() - 1;
    send_stream(1, eb, 1);
    check("w1_sync", bus.sync, 1);
    read_packet(8'h68);

    // PacketNext with nothing held is ignored
    bus.PacketNext = 1'b1;
    @(negedge clk);
    bus.PacketNext = 1'b0;
    @(negedge clk);
    check("ignored_next_out", bus.PacketOut, 16'h6807);
    check("ignored_next_final", bus.PacketFinal, 8'h68);
    check("ignored_next_avail", bus.PacketAvail, 0);

    // Width 2
    bus.width = 2'b01;
    push_sync();
    push_frame(f1, 1);
    eb = bits_q.size() - 1;
    send_stream(2, eb, 1);
    read_packet(8'h68);

    // Width 4
    bus.width = 2'b11;
    push_sync();
    push_frame(f1, 1);
    eb = bits_q.size() - 1;
    send_stream(4, eb, 1);
    read_packet(8'h68);

    // Sync shifted by 3 bits behind junk, width 4 (match lands mid-element)
    do_reset();
    check("rst2_sync", bus.sync, 0);
    push_byte(8'hFE);
    bits_q.push_back(1'b0); bits_q.push_back(1'b0); bits_q.push_back(1'b0);
    push_sync();
    push_frame(f1, 1);
    eb = bits_q.size() - 1;
    send_stream(4, eb, 1);
    check("shift_sync", bus.sync, 1);
    read_packet(8'h68);

    // Reset mid-frame
    push_sync();
    for (int i = 0; i < 8; i++) push_byte(f2[i]);
    send_stream(4, -1, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sync", bus.sync, 0);
    check("midrst_avail", bus.PacketAvail, 0);
    check("midrst_out", bus.PacketOut, 0);
    check("midrst_final", bus.PacketFinal, 0);
    check("midrst_tracenext", bus.TraceNext, 0);
    rst = 1'b0;
    @(negedge clk);
    push_frame(f1, 0);
    send_stream(4, -1, 0);
    check("postrst_sync", bus.sync, 0);
    check("postrst_avail", bus.PacketAvail, 0);

    // Two frames back-to-back, width 2: second overwrites the first
    bus.width = 2'b01;
    push_sync();
    push_frame(f1, 0);
    push_frame(f2, 1);
    eb = bits_q.size() - 1;
    send_stream(2, eb, 0);
    read_packet(8'hA5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
